fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side controller for the `FiFo` block. Drives `pop` against the FIFO's first-word-fall-through `dout`/`empty` outputs and re-presents the words on a valid/ready stream with burst framing (`m_last`). A two-entry output buffer means `fifo_pop` never depends combinationally on `m_ready`. It sits between the FIFO and any downstream consumer that can apply backpressure.

## Interface
- `DATA_WIDTH`, 2, width of FIFO words and stream data
- `BURST_LEN`, 4, beats per burst; `m_last` marks beat `BURST_LEN-1`; legal range 1..256
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `enable`  in  1  start/continue reading; deassertion requests a drain
- `fifo_dout`  in  DATA_WIDTH  FIFO head word, valid when `fifo_empty`=0
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_pop`  out  1  consume FIFO head at this clock edge
- `m_data`  out  DATA_WIDTH  stream data (buffer head)
- `m_valid`  out  1  stream word present
- `m_ready`  in  1  consumer accepts the word this edge
- `m_last`  out  1  current word is the final beat of a burst
- `busy`  out  1  state is not IDLE

## Operation
- Buffer: two registers, `head` and `tail`, plus occupancy `cnt` (0..2). `m_data`=`head`. `m_valid`=(`cnt`!=0).
- Accept: `acc` = `m_valid` && `m_ready`.
- Pop rule: `fifo_pop` = (state==RUN) && !`fifo_empty` && (`cnt`<2). It depends only on registered state and `fifo_empty`.
- Write path when `fifo_pop`:
  - If `cnt`==0, or `cnt`==1 with `acc`, `fifo_dout` goes to `head`.
  - Otherwise it goes to `tail`.
- Shift: when `acc` with `cnt`==2, `tail` moves to `head`.
- Count update: `cnt` += `fifo_pop` − `acc`.
- Beat counter `beat` (8 bits): increments on `acc` and wraps to 0 after `BURST_LEN-1`. `m_last` = `m_valid` && (`beat`==`BURST_LEN-1`). With `BURST_LEN`=1, every valid word is last.
- `beat` persists across IDLE. Only reset clears it, so bursts are never renumbered mid-stream.
- States:
  - IDLE: `fifo_pop`=0. `enable`=1 → RUN.
  - RUN: pops per the pop rule. `enable`=0 → DRAIN.
  - DRAIN: `fifo_pop`=0 and buffered words are still delivered. When `cnt`==0 → IDLE, or when `cnt`==1 with `acc`. `enable`=1 while in DRAIN → RUN.
- `busy` = state!=IDLE.

## Timing
- Reset values: state IDLE, `cnt`=0, `beat`=0, `head`=`tail`=0. Outputs are `fifo_pop`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0.
- Startup: from `enable` rising, RUN is entered at the next edge, and the first `fifo_pop` can occur in that cycle.
- Latency: a word popped at edge t appears with `m_valid`=1 immediately after edge t.
- Throughput: 1 word/cycle sustained while `m_ready`=1 and the FIFO is non-empty. Occupancy settles at 1.
- Backpressure: with `m_ready`=0, at most 2 words are popped, then `fifo_pop` stays 0. After `m_ready` returns, popping resumes one cycle later.
- Empty FIFO: `fifo_pop`=0, and buffered words drain normally.
- Simultaneous pop and accept at `cnt`=1: `cnt` stays 1 and `head` takes the new word.
- Async reset mid-burst: all state clears immediately. Words already popped and held in the buffer are lost. This is documented, not an error.

## Configuration
- `FIFO_READER_STATS_EN`: when defined, adds output port `rd_count` (out, 16) that counts accepted beats. It increments on `acc`, wraps at 0xFFFF→0, and resets to 0.
- When not defined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Reset: hold `rst`=0 with FIFO words present and `enable`=1 → `fifo_pop`=0, `m_valid`=0, `busy`=0. Release `rst` → RUN one edge later, then `fifo_pop`=1.
- Stream: FIFO holds 1,2,3,0, `m_ready`=1, `BURST_LEN`=4 → `m_data` 1,2,3,0 on consecutive cycles, with `m_last`=1 only on the 0.
- Backpressure: FIFO holds 1,2,3, `m_ready`=0 → exactly 2 pops. `fifo_pop` stays 0, `m_data`=1. Raise `m_ready` → 1,2,3 in order, no loss or duplication.
- Drain: deassert `enable` with `cnt`=2 → no further pops. Words are delivered, then IDLE with `busy`=0 and the FIFO still holding the remainder.
- Empty boundary: pop the last FIFO word while `fifo_empty` rises → `fifo_pop` drops in the same cycle and `m_valid` falls after acceptance.
- With `FIFO_READER_STATS_EN`: 5 accepted beats → `rd_count`=5. Reset → 0.

Source files
------------

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_reader
// Purpose  : Read-side controller for a first-word-fall-through FIFO. Pops
//            words into a two-entry output buffer and presents them on a
//            valid/ready stream with burst framing (m_last on the final beat).
//            fifo_pop depends only on registered state and fifo_empty, never
//            combinationally on m_ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : width of FIFO words and stream data
//   BURST_LEN  : beats per burst (1..256); m_last marks beat BURST_LEN-1
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   enable     in   start/continue reading; low requests a drain
//   fifo_dout  in   FIFO head word (valid when fifo_empty = 0)
//   fifo_empty in   FIFO empty flag
//   fifo_pop   out  consume FIFO head at this edge
//   m_data     out  stream data (buffer head)
//   m_valid    out  stream word present
//   m_ready    in   consumer accepts the word this edge
//   m_last     out  current word is the last beat of a burst
//   busy       out  controller is not idle
//   rd_count   out  accepted-beat counter (only with FIFO_READER_STATS_EN)
// Build option
//   FIFO_READER_STATS_EN : adds the 16-bit rd_count output
// ============================================================================
module fifo_reader #(
  parameter int DATA_WIDTH = 2,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]           rd_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [1:0]            cnt;
  logic [7:0]            beat;
  logic                  acc;

  assign m_data   = head;
  assign m_valid  = (cnt != 2'd0);
  assign acc      = m_valid && m_ready;
  // Only registered state and fifo_empty feed the pop decision, so there is
  // no combinational path from m_ready to fifo_pop.
  assign fifo_pop = (state == RUN) && !fifo_empty && (cnt < 2'd2);
  assign m_last   = m_valid && (beat == LAST_BEAT);
  assign busy     = (state != IDLE);

  // Output buffer and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      // A popped word lands in head when head is free after this edge
      // (empty buffer, or the single held word leaving now); else in tail.
      if (fifo_pop) begin
        if ((cnt == 2'd0) || ((cnt == 2'd1) && acc)) begin
          head <= fifo_dout;
        end else begin
          tail <= fifo_dout;
        end
      end
      // Pop is blocked at cnt==2, so the shift never collides with a write.
      if (acc && (cnt == 2'd2)) begin
        head <= tail;
      end
      cnt <= cnt + {1'b0, fifo_pop} - {1'b0, acc};
    end
  end

  // Beat counter; survives IDLE so bursts are never renumbered mid-stream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat <= 8'd0;
    end else if (acc) begin
      if (beat == LAST_BEAT) begin
        beat <= 8'd0;
      end else begin
        beat <= beat + 8'd1;
      end
    end
  end

  // Control state machine
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RUN;
        end
        RUN: begin
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if ((cnt == 2'd0) || ((cnt == 2'd1) && acc)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_READER_STATS_EN
  // Accepted-beat counter; wraps naturally at 0xFFFF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= 16'd0;
    end else if (acc) begin
      rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_reader
// Purpose  : Directed self-checking bench for fifo_reader. A small FWFT FIFO
//            model feeds the DUT; outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_reader;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [1:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_pop;
  logic [1:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0] rd_count;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // FWFT FIFO model
  logic [1:0] mem [16];
  logic [3:0] rd = 4'd0;
  logic [3:0] wr = 4'd0;

  assign fifo_empty = (rd == wr);
  assign fifo_dout  = mem[rd];

  always @(posedge clk) begin
    if (fifo_pop) begin
      rd   <= rd + 4'd1;
      pops <= pops + 1;
    end
  end

  fifo_reader #(.DATA_WIDTH(2), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .rd_count   (rd_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] v);
    mem[wr] = v;
    wr = wr + 4'd1;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    enable  = 1'b1;
    m_ready = 1'b1;
    load(2'd1); load(2'd2); load(2'd3); load(2'd0);

    // Reset held with data present and enable high
    nxt(); nxt();
    chk("rst_pop",   fifo_pop, 0);
    chk("rst_valid", m_valid,  0);
    chk("rst_busy",  busy,     0);
    chk("rst_data",  m_data,   0);
    chk("rst_last",  m_last,   0);

    // Release: RUN one edge later, then pop
    rst = 1'b1;
    nxt();
    chk("start_busy",  busy,     1);
    chk("start_pop",   fifo_pop, 1);
    chk("start_valid", m_valid,  0);

    // Stream 1,2,3,0 with m_last only on the 4th beat
    nxt();
    chk("s0_data", m_data, 1); chk("s0_valid", m_valid, 1); chk("s0_last", m_last, 0);
    nxt();
    chk("s1_data", m_data, 2); chk("s1_last", m_last, 0);
    nxt();
    chk("s2_data", m_data, 3); chk("s2_last", m_last, 0); chk("s2_pop", fifo_pop, 1);
    nxt();
    chk("s3_data", m_data, 0); chk("s3_last", m_last, 1);
    chk("empty_pop", fifo_pop, 0); chk("s3_valid", m_valid, 1);
    nxt();
    chk("s_end_valid", m_valid, 0); chk("s_end_last", m_last, 0); chk("s_end_busy", busy, 1);
    chk("s_pops", pops, 4);

    // Backpressure: at most 2 pops with m_ready low
    m_ready = 1'b0;
    load(2'd1); load(2'd2); load(2'd3);
    #1;
    chk("bp_pop0", fifo_pop, 1);
    nxt();
    chk("bp_d0", m_data, 1); chk("bp_pop1", fifo_pop, 1);
    nxt();
    chk("bp_pop2", fifo_pop, 0); chk("bp_d1", m_data, 1);
    nxt();
    chk("bp_pop3", fifo_pop, 0); chk("bp_d2", m_data, 1); chk("bp_valid", m_valid, 1);
    chk("bp_pops", pops, 6);
    m_ready = 1'b1;
    nxt();
    chk("bp_r0", m_data, 2); chk("bp_resume_pop", fifo_pop, 1);
    nxt();
    chk("bp_r1", m_data, 3); chk("bp_r1_pop", fifo_pop, 0);
    nxt();
    chk("bp_end_valid", m_valid, 0);
    chk("bp_total_pops", pops, 7);

    // Drain with two words buffered; beat counter now sits at 3
    m_ready = 1'b0;
    load(2'd1); load(2'd2); load(2'd3);
    nxt(); nxt();
    chk("dr_full_pop", fifo_pop, 0);
    enable = 1'b0;
    nxt();
    chk("dr_busy", busy, 1); chk("dr_pop", fifo_pop, 0);
    chk("dr_d0", m_data, 1); chk("dr_last", m_last, 1);
    m_ready = 1'b1;
    nxt();
    chk("dr_d1", m_data, 2); chk("dr_last1", m_last, 0);
    chk("dr_busy1", busy, 1); chk("dr_pop1", fifo_pop, 0);
    nxt();
    chk("dr_idle", busy, 0); chk("dr_valid", m_valid, 0); chk("dr_pop2", fifo_pop, 0);
    chk("dr_fifo_left", 32'(wr - rd), 1);
    chk("dr_pops", pops, 9);
`ifdef FIFO_READER_STATS_EN
    chk("stats_count", rd_count, 9);
`endif

    // Asynchronous reset mid-burst discards the buffered word
    enable  = 1'b1;
    m_ready = 1'b0;
    nxt();
    chk("ar_pop", fifo_pop, 1); chk("ar_busy", busy, 1);
    nxt();
    chk("ar_valid", m_valid, 1); chk("ar_data", m_data, 3);
    #2 rst = 1'b0;
    #1;
    chk("ar_valid0", m_valid, 0); chk("ar_busy0", busy, 0);
    chk("ar_pop0", fifo_pop, 0); chk("ar_data0", m_data, 0);
`ifdef FIFO_READER_STATS_EN
    chk("stats_reset", rd_count, 0);
`endif
    nxt();
    rst = 1'b1;
    nxt(); nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
